// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: stage-tagged pipeline inputs and the stall/flush/forward controls.
// The pipeline side uses the master modport, hazard_ctrl uses the slave modport.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       rs1_a_dc_i;
    logic [4:0]       rs2_a_dc_i;
    logic [4:0]       rs1_a_ex_i;
    logic [4:0]       rs2_a_ex_i;
    logic [4:0]       rd_a_ex_i;
    logic [4:0]       rd_a_mem_i;
    logic [4:0]       rd_a_wb_i;
    logic             reg_write_mem_i;
    logic             reg_write_wb_i;
    logic             load_ex_i;
    logic             pc_src_ex_i;
    logic             mdu_start_ex_i;
    logic [1:0]       fwd_a_ex_o;
    logic [1:0]       fwd_b_ex_o;
    logic             stall_fe_o;
    logic             stall_dc_o;
    logic             stall_ex_o;
    logic             flush_dc_o;
    logic             flush_ex_o;
    logic             flush_mem_o;
    logic             mdu_busy_o;
    logic             mdu_done_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output rs1_a_dc_i, rs2_a_dc_i, rs1_a_ex_i, rs2_a_ex_i, rd_a_ex_i, rd_a_mem_i,
               rd_a_wb_i, reg_write_mem_i, reg_write_wb_i, load_ex_i, pc_src_ex_i,
               mdu_start_ex_i,
        input  fwd_a_ex_o, fwd_b_ex_o, stall_fe_o, stall_dc_o, stall_ex_o, flush_dc_o,
               flush_ex_o, flush_mem_o, mdu_busy_o, mdu_done_o, stall_cnt_o
    );

    modport slave (
        input  rs1_a_dc_i, rs2_a_dc_i, rs1_a_ex_i, rs2_a_ex_i, rd_a_ex_i, rd_a_mem_i,
               rd_a_wb_i, reg_write_mem_i, reg_write_wb_i, load_ex_i, pc_src_ex_i,
               mdu_start_ex_i,
        output fwd_a_ex_o, fwd_b_ex_o, stall_fe_o, stall_dc_o, stall_ex_o, flush_dc_o,
               flush_ex_o, flush_mem_o, mdu_busy_o, mdu_done_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: EX forwarding selects, load-use stall,
// taken-branch flush, multi-cycle MDU sequencing and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned MDU_CYCLES = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned CW = $clog2(MDU_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [1:0] fwd_a, fwd_b;
    logic       mdu_stall, lu, br;
    logic       stall_fe, stall_dc, stall_ex, flush_dc, flush_ex, flush_mem;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (hz.reg_write_mem_i && (hz.rd_a_mem_i != 5'd0) && (hz.rd_a_mem_i == rs))
            sel = 2'b10;
        else if (hz.reg_write_wb_i && (hz.rd_a_wb_i != 5'd0) && (hz.rd_a_wb_i == rs))
            sel = 2'b01;
        return sel;
    endfunction

    // The counter is loaded on entry to BUSY and DONE follows the cycle it would
    // decrement to zero, giving MDU_CYCLES-2 BUSY cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (hz.mdu_start_ex_i) begin
                    state_d = (MDU_CYCLES == 2) ? DONE : BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q <= CNT_ONE) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fwd_a     = fwd_sel(hz.rs1_a_ex_i);
        fwd_b     = fwd_sel(hz.rs2_a_ex_i);
        mdu_stall = ((state_q == IDLE) && hz.mdu_start_ex_i) || (state_q == BUSY);
        lu        = hz.load_ex_i && (hz.rd_a_ex_i != 5'd0) &&
                    ((hz.rd_a_ex_i == hz.rs1_a_dc_i) || (hz.rd_a_ex_i == hz.rs2_a_dc_i)) &&
                    !mdu_stall;
        br        = hz.pc_src_ex_i && !mdu_stall;
        stall_fe  = mdu_stall || (lu && !br);
        stall_dc  = mdu_stall || (lu && !br);
        stall_ex  = mdu_stall;
        flush_dc  = br;
        flush_ex  = br || lu;
        flush_mem = mdu_stall;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_fe && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign hz.fwd_a_ex_o  = rst_ni ? fwd_a : 2'b00;
    assign hz.fwd_b_ex_o  = rst_ni ? fwd_b : 2'b00;
    assign hz.stall_fe_o  = rst_ni && stall_fe;
    assign hz.stall_dc_o  = rst_ni && stall_dc;
    assign hz.stall_ex_o  = rst_ni && stall_ex;
    assign hz.flush_dc_o  = rst_ni && flush_dc;
    assign hz.flush_ex_o  = rst_ni && flush_ex;
    assign hz.flush_mem_o = rst_ni && flush_mem;
    assign hz.mdu_busy_o  = rst_ni && (state_q == BUSY);
    assign hz.mdu_done_o  = rst_ni && (state_q == DONE);
    assign hz.stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_CYCLES=4, CNT_W=4): stimulus pushes expected
// output vectors into a queue, a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    localparam int W = 16;
    // flag order: stall_fe stall_dc stall_ex flush_dc flush_ex flush_mem busy done
    localparam logic [7:0] F_NONE = 8'b0000_0000;
    localparam logic [7:0] F_LU   = 8'b1100_1000;
    localparam logic [7:0] F_BR   = 8'b0001_1000;
    localparam logic [7:0] F_MS   = 8'b1110_0100;
    localparam logic [7:0] F_MB   = 8'b1110_0110;
    localparam logic [7:0] F_DN   = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [W-1:0] exp_q[$];
    string        name_q[$];

    hazard_ctrl_if #(.CNT_W(4)) hz ();

    hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .hz    (hz)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic [7:0] flags, input logic [3:0] cnt);
        return {fa, fb, flags, cnt};
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        hz.rs1_a_dc_i = 5'd0;  hz.rs2_a_dc_i = 5'd0;
        hz.rs1_a_ex_i = 5'd0;  hz.rs2_a_ex_i = 5'd0;
        hz.rd_a_ex_i  = 5'd0;  hz.rd_a_mem_i = 5'd0;  hz.rd_a_wb_i = 5'd0;
        hz.reg_write_mem_i = 1'b0;  hz.reg_write_wb_i = 1'b0;
        hz.load_ex_i = 1'b0;  hz.pc_src_ex_i = 1'b0;  hz.mdu_start_ex_i = 1'b0;
    endtask

    task automatic push_exp(input string n, input logic [W-1:0] e);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        set_idle();
        hz.rd_a_mem_i = 5'd5; hz.reg_write_mem_i = 1'b1; hz.rs1_a_ex_i = 5'd5;
        hz.pc_src_ex_i = 1'b1; hz.mdu_start_ex_i = 1'b1;
        push_exp("reset_held0", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc();
        push_exp("reset_held1", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc();
        rst_n = 1'b1;
        set_idle();
        push_exp("reset_idle", mk(2'b00, 2'b00, F_NONE, 4'd0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] act, e;
        string n;
        assert (!(hz.load_ex_i && hz.mdu_start_ex_i));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act = {hz.fwd_a_ex_o, hz.fwd_b_ex_o, hz.stall_fe_o, hz.stall_dc_o, hz.stall_ex_o,
                   hz.flush_dc_o, hz.flush_ex_o, hz.flush_mem_o, hz.mdu_busy_o,
                   hz.mdu_done_o, hz.stall_cnt_o};
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    initial begin
        set_idle();
        do_reset();

        // forwarding
        cyc(); set_idle();
        hz.rd_a_mem_i = 5'd5; hz.reg_write_mem_i = 1'b1;
        hz.rd_a_wb_i = 5'd5; hz.reg_write_wb_i = 1'b1; hz.rs1_a_ex_i = 5'd5;
        push_exp("fwd_mem_prio", mk(2'b10, 2'b00, F_NONE, 4'd0));
        cyc(); hz.reg_write_mem_i = 1'b0;
        push_exp("fwd_wb", mk(2'b01, 2'b00, F_NONE, 4'd0));
        cyc(); hz.reg_write_mem_i = 1'b1;
        hz.rd_a_mem_i = 5'd0; hz.rd_a_wb_i = 5'd0; hz.rs1_a_ex_i = 5'd0;
        push_exp("fwd_x0", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc(); hz.rs1_a_ex_i = 5'd3; hz.rs2_a_ex_i = 5'd9;
        hz.rd_a_mem_i = 5'd9; hz.rd_a_wb_i = 5'd3;
        push_exp("fwd_a_wb_b_mem", mk(2'b01, 2'b10, F_NONE, 4'd0));

        // load-use
        cyc(); set_idle();
        hz.load_ex_i = 1'b1; hz.rd_a_ex_i = 5'd7; hz.rs2_a_dc_i = 5'd7;
        push_exp("lu_rs2", mk(2'b00, 2'b00, F_LU, 4'd0));
        cyc(); set_idle();
        push_exp("lu_bubble", mk(2'b00, 2'b00, F_NONE, 4'd1));
        cyc(); hz.load_ex_i = 1'b1;
        push_exp("lu_x0", mk(2'b00, 2'b00, F_NONE, 4'd1));
        cyc(); hz.rd_a_ex_i = 5'd12; hz.rs1_a_dc_i = 5'd12;
        push_exp("lu_rs1", mk(2'b00, 2'b00, F_LU, 4'd1));

        // branch overrides load-use
        cyc(); set_idle();
        hz.load_ex_i = 1'b1; hz.rd_a_ex_i = 5'd7; hz.rs2_a_dc_i = 5'd7; hz.pc_src_ex_i = 1'b1;
        push_exp("br_over_lu", mk(2'b00, 2'b00, F_BR, 4'd2));
        cyc(); set_idle(); hz.pc_src_ex_i = 1'b1;
        push_exp("br_only", mk(2'b00, 2'b00, F_BR, 4'd2));

        // MDU sequencing from a clean counter
        do_reset();
        cyc(); hz.mdu_start_ex_i = 1'b1;
        push_exp("mdu_c0", mk(2'b00, 2'b00, F_MS, 4'd0));
        cyc(); hz.pc_src_ex_i = 1'b1;
        push_exp("mdu_c1_br_masked", mk(2'b00, 2'b00, F_MB, 4'd1));
        cyc(); hz.pc_src_ex_i = 1'b0;
        push_exp("mdu_c2", mk(2'b00, 2'b00, F_MB, 4'd2));
        cyc();
        push_exp("mdu_c3_done", mk(2'b00, 2'b00, F_DN, 4'd3));
        cyc(); hz.mdu_start_ex_i = 1'b0;
        push_exp("mdu_c4_idle", mk(2'b00, 2'b00, F_NONE, 4'd3));
        cyc(); hz.mdu_start_ex_i = 1'b1;
        push_exp("mdu2_c0", mk(2'b00, 2'b00, F_MS, 4'd3));
        cyc(); push_exp("mdu2_c1", mk(2'b00, 2'b00, F_MB, 4'd4));
        cyc(); push_exp("mdu2_c2", mk(2'b00, 2'b00, F_MB, 4'd5));
        cyc(); push_exp("mdu2_done", mk(2'b00, 2'b00, F_DN, 4'd6));
        cyc(); push_exp("mdu3_b2b_c0", mk(2'b00, 2'b00, F_MS, 4'd6));
        cyc(); push_exp("mdu3_c1", mk(2'b00, 2'b00, F_MB, 4'd7));

        // reset in the middle of BUSY
        cyc(); rst_n = 1'b0;
        push_exp("rst_mid_busy", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc(); push_exp("rst_mid_held", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc(); rst_n = 1'b1; hz.mdu_start_ex_i = 1'b0;
        push_exp("rst_release_idle", mk(2'b00, 2'b00, F_NONE, 4'd0));
        cyc(); hz.mdu_start_ex_i = 1'b1;
        push_exp("post_rst_c0", mk(2'b00, 2'b00, F_MS, 4'd0));
        cyc(); push_exp("post_rst_c1", mk(2'b00, 2'b00, F_MB, 4'd1));
        cyc(); push_exp("post_rst_c2", mk(2'b00, 2'b00, F_MB, 4'd2));
        cyc(); push_exp("post_rst_done", mk(2'b00, 2'b00, F_DN, 4'd3));
        cyc(); hz.mdu_start_ex_i = 1'b0;
        push_exp("post_rst_idle", mk(2'b00, 2'b00, F_NONE, 4'd3));

        // counter saturation
        do_reset();
        for (int i = 0; i < 23; i++) begin
            cyc(); set_idle();
            hz.load_ex_i = 1'b1; hz.rd_a_ex_i = 5'd7; hz.rs1_a_dc_i = 5'd7;
            push_exp($sformatf("sat_%0d", i),
                     mk(2'b00, 2'b00, F_LU, (i > 15) ? 4'd15 : 4'(i)));
        end
        cyc(); set_idle();
        push_exp("sat_hold", mk(2'b00, 2'b00, F_NONE, 4'd15));

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
